systolic_skew_feeder: RTL and testbench

- Upstream operand feeder for one edge of the N×N PE grid. Each grid's west edge and north edge gets one instance.
- Buffers N operand vectors, then replays them as diagonally skewed lane streams. Lane i is delayed i cycles, so matching A/B elements meet in PE(i,j) on the same cycle.
- Lane outputs drive inp_west of row i (west instance) or inp_north of column i (north instance).
- Lanes carry zero outside their valid window. The PEs accumulate, so zero products are harmless.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/skew_lane_mux.sv | 29 ++
 rtl/systolic_skew_feeder.sv | 140 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type and lane slicing helper for the systolic operand feeders.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Low bit position of lane/element 'idx' inside a packed vector of dw-bit elements.
  function automatic int lane_lo(input int idx, input int dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Per-lane skew select: returns element (t - LANE) of this lane's column, or zero outside the window.
// Latency: combinational.
// Backpressure: none.
module skew_lane_mux
  import systolic_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int LANE = 0,
  parameter int TW   = 3
) (
  input  logic [N*DW-1:0] col,
  input  logic [TW-1:0]   t,
  output logic [DW-1:0]   lane
);

  localparam int LW = TW + 1;

  // Match t against LANE+k for every vector k; at most one k can hit, none outside the diagonal window.
  always_comb begin
    lane = '0;
    for (int k = 0; k < N; k++) begin
      if ({1'b0, t} == LW'(LANE + k)) begin
        lane = col[lane_lo(k, DW) +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for one PE-grid edge: loads N vectors, then replays them with lane i delayed i cycles.
// Latency: start sampled in FULL at cycle c -> beat t=0 at c+1, last beat (out_last) at c+2N-1.
// Backpressure: in_ready drops once N vectors are held; the output stream cannot be stalled.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            start,
  output logic            busy,
  output logic            out_valid,
  output logic            out_last,
  output logic [N*DW-1:0] out_data
);

  localparam int CW = $clog2(N + 1);
  // A single-lane feeder still needs a one-bit step counter.
  localparam int TW = (N > 1) ? $clog2(2 * N - 1) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(2 * N - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   t;
  logic [TW-1:0]   t_sel;
  logic            load_fire;
  logic [N*DW-1:0] vec_mem [N];
  logic [N*DW-1:0] col     [N];
  logic [N*DW-1:0] beat;

  assign load_fire = in_valid && in_ready && (state == LOAD);

  // Step index of the beat being registered this edge: 0 when launching from FULL, t+1 while streaming.
  always_comb begin
    t_sel = '0;
    if (state == STREAM) begin
      t_sel = t + TW'(1);
    end
  end

  // Transpose the buffer so each lane mux sees its own element from every stored vector.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    for (genvar gk = 0; gk < N; gk++) begin : g_vec
      assign col[gi][lane_lo(gk, DW) +: DW] = vec_mem[gk][lane_lo(gi, DW) +: DW];
    end

    skew_lane_mux #(
      .N    (N),
      .DW   (DW),
      .LANE (gi),
      .TW   (TW)
    ) u_mux (
      .col  (col[gi]),
      .t    (t_sel),
      .lane (beat[lane_lo(gi, DW) +: DW])
    );
  end

  // Operand buffer: written only on accepted load beats, deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      for (int k = 0; k < N; k++) begin
        if (cnt == CW'(k)) begin
          vec_mem[k] <= in_data;
        end
      end
    end
  end

  // Load/stream sequencing with fully registered handshake and stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      t         <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          // start is ignored here, even on the beat that completes the buffer.
          if (load_fire) begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              state    <= FULL;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        FULL: begin
          if (start) begin
            state     <= STREAM;
            t         <= '0;
            out_valid <= 1'b1;
            out_last  <= (t_sel == T_LAST);
            out_data  <= beat;
          end
        end
        STREAM: begin
          // t names the beat currently on the outputs; once the final beat has been shown, go idle.
          if (t == T_LAST) begin
            state     <= LOAD;
            cnt       <= '0;
            t         <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
          end else begin
            t        <= t_sel;
            out_last <= (t_sel == T_LAST);
            out_data <= beat;
          end
        end
        default: begin
          state     <= LOAD;
          cnt       <= '0;
          t         <= '0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench: west/north feeder pair driven with directed and random loads, checked against a skew model and a 4x4 PE grid.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int VW = N * DW;
  localparam int NB = 2 * N - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          start = 1'b0;
  logic [VW-1:0] in_data_w = '0;
  logic [VW-1:0] in_data_n = '0;

  logic          in_ready_w, busy_w, out_valid_w, out_last_w;
  logic [VW-1:0] out_data_w;
  logic          in_ready_n, busy_n, out_valid_n, out_last_n;
  logic [VW-1:0] out_data_n;

  int checks = 0;
  int fails  = 0;

  // Vectors offered by the next load, and what each feeder should now hold.
  logic [VW-1:0] nv_w  [N];
  logic [VW-1:0] nv_n  [N];
  logic [VW-1:0] mdl_w [N];
  logic [VW-1:0] mdl_n [N];
  logic [VW-1:0] gold  [NB];

  int mat_a [N][N];
  int mat_b [N][N];

  // Behavioural PE grid: A flows east, B flows south, each PE multiply-accumulates to 16 bits.
  logic          grid_clr = 1'b0;
  logic [DW-1:0] a_pipe [N][N];
  logic [DW-1:0] b_pipe [N][N];
  logic [15:0]   acc    [N][N];

  systolic_skew_feeder #(.N(N), .DW(DW)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data_w),
    .start(start), .busy(busy_w), .out_valid(out_valid_w), .out_last(out_last_w), .out_data(out_data_w)
  );

  systolic_skew_feeder #(.N(N), .DW(DW)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data_n),
    .start(start), .busy(busy_n), .out_valid(out_valid_n), .out_last(out_last_n), .out_data(out_data_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_in = (j == 0) ? out_data_w[i*DW +: DW] : a_pipe[i][(j > 0) ? j - 1 : 0];
        b_in = (i == 0) ? out_data_n[j*DW +: DW] : b_pipe[(i > 0) ? i - 1 : 0][j];
        if (grid_clr) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end else begin
          a_pipe[i][j] <= a_in;
          b_pipe[i][j] <= b_in;
          acc[i][j]    <= acc[i][j] + 16'(a_in) * 16'(b_in);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Skewed beat t from held vectors: lane i shows vector (t-i) when that vector exists, else zero.
  function automatic logic [VW-1:0] exp_beat(input bit north, input int t);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = t - i;
      if (k >= 0 && k < N) begin
        r[i*DW +: DW] = north ? mdl_n[k][i*DW +: DW] : mdl_w[k][i*DW +: DW];
      end
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      nv_w[k] = VW'($urandom);
      nv_n[k] = VW'($urandom);
    end
  endtask

  // Build west/north vectors from matrices: west vector k lane i = A[i][k], north vector k lane j = B[k][j].
  task automatic fill_matrices();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = int'($urandom_range(0, 255));
        mat_b[i][j] = int'($urandom_range(0, 255));
      end
    end
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        nv_w[k][i*DW +: DW] = DW'(mat_a[i][k]);
        nv_n[k][i*DW +: DW] = DW'(mat_b[k][i]);
      end
    end
  endtask

  task automatic load_both(input bit random_gaps, input bit start_on_last);
    int got;
    int cyc;
    bit acc_now;
    got = 0;
    cyc = 0;
    while (got < N && cyc < 200) begin
      in_valid  = random_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data_w = nv_w[got];
      in_data_n = nv_n[got];
      start     = start_on_last && (got == N - 1) && in_valid;
      acc_now   = in_valid && in_ready_w;
      tick();
      cyc++;
      if (acc_now) begin
        mdl_w[got] = nv_w[got];
        mdl_n[got] = nv_n[got];
        got++;
      end
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    in_data_w = VW'($urandom);
    in_data_n = VW'($urandom);
    check("load_beats_accepted", 64'(got), 64'(N));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid_w), 64'd0);
    check({tag, "_out_last"},  64'(out_last_w),  64'd0);
    check({tag, "_out_data"},  64'(out_data_w),  64'd0);
    check({tag, "_in_ready"},  64'(in_ready_w),  64'd1);
    check({tag, "_busy"},      64'(busy_w),      64'd0);
    check({tag, "_n_idle"},    64'({out_valid_n, out_last_n, busy_n, in_ready_n}), 64'b0001);
    check({tag, "_n_data"},    64'(out_data_n),  64'd0);
  endtask

  // Pulse start from FULL and check every beat; stop_at < NB returns right after showing beat stop_at.
  task automatic run_stream(input bit use_gold, input int stop_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < NB; t++) begin
      check($sformatf("beat%0d_valid", t), 64'({out_valid_w, out_valid_n}), 64'b11);
      check($sformatf("beat%0d_last", t), 64'({out_last_w, out_last_n}), (t == NB - 1) ? 64'b11 : 64'b00);
      check($sformatf("beat%0d_west", t), 64'(out_data_w), 64'(exp_beat(1'b0, t)));
      check($sformatf("beat%0d_north", t), 64'(out_data_n), 64'(exp_beat(1'b1, t)));
      if (use_gold) begin
        check($sformatf("beat%0d_table", t), 64'(out_data_w), 64'(gold[t]));
      end
      if (t == stop_at) begin
        return;
      end
      tick();
    end
    check_idle("after_stream");
  endtask

  initial begin
    gold[0] = 32'h00000001;
    gold[1] = 32'h0000020B;
    gold[2] = 32'h00030C15;
    gold[3] = 32'h040D161F;
    gold[4] = 32'h0E172000;
    gold[5] = 32'h18210000;
    gold[6] = 32'h22000000;

    // Reset held for three cycles.
    rst = 1'b1;
    tick();
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;

    // Normal run with the directed 10*k+i+1 pattern.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        nv_w[k][i*DW +: DW] = DW'(10 * k + i + 1);
        nv_n[k][i*DW +: DW] = DW'(10 * k + i + 1);
      end
    end
    load_both(1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready_w), 64'd0);
    check("full_busy", 64'(busy_w), 64'd1);
    run_stream(1'b1, NB);

    // Handshake: random in_valid gaps, then an extra beat that must not be stored.
    fill_random();
    load_both(1'b1, 1'b0);
    check("hs_in_ready_low", 64'(in_ready_w), 64'd0);
    in_valid  = 1'b1;
    in_data_w = '1;
    in_data_n = '1;
    tick();
    tick();
    tick();
    check("hs_fifth_ignored_rdy", 64'(in_ready_w), 64'd0);
    check("hs_fifth_no_stream", 64'(out_valid_w), 64'd0);
    in_valid = 1'b0;
    run_stream(1'b0, NB);

    // Early start: in LOAD, and coincident with the final load beat.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("early_start_load_valid", 64'(out_valid_w), 64'd0);
    check("early_start_load_busy", 64'(busy_w), 64'd0);
    fill_random();
    load_both(1'b0, 1'b1);
    check("early_start_last_valid", 64'(out_valid_w), 64'd0);
    check("early_start_last_busy", 64'(busy_w), 64'd1);
    tick();
    tick();
    check("early_start_hold_valid", 64'(out_valid_w), 64'd0);
    run_stream(1'b0, NB);

    // Mid-stream reset at t=3, then reload with all-ones data.
    fill_random();
    load_both(1'b0, 1'b0);
    run_stream(1'b0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    start = 1'b1;
    for (int c = 0; c < 2 * N; c++) begin
      tick();
      check($sformatf("midrst_quiet%0d", c), 64'({out_valid_w, out_last_w}), 64'b00);
    end
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      nv_w[k] = '1;
      nv_n[k] = '1;
    end
    load_both(1'b0, 1'b0);
    run_stream(1'b0, NB);

    // Back-to-back matrix runs feeding the PE grid model.
    fill_matrices();
    load_both(1'b0, 1'b0);
    run_stream(1'b0, NB);
    fill_matrices();
    grid_clr = 1'b1;
    load_both(1'b0, 1'b0);
    grid_clr = 1'b0;
    run_stream(1'b0, NB);
    for (int c = 0; c < 2 * N; c++) begin
      tick();
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int sum;
        sum = 0;
        for (int k = 0; k < N; k++) begin
          sum += mat_a[i][k] * mat_b[k][j];
        end
        check($sformatf("grid_c%0d%0d", i, j), 64'(acc[i][j]), 64'(sum & 16'hFFFF));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
